// File: rtl/spi_pkg.sv
// Shared constants for the SPI MMIO controller: register offsets, status bit
// positions and the shift-engine state encoding.
package spi_pkg;

   localparam logic [7:0] SCKDIV = 8'h00;
   localparam logic [7:0] CSMODE = 8'h18;
   localparam logic [7:0] LOOP   = 8'h40;
   localparam logic [7:0] TXDATA = 8'h48;
   localparam logic [7:0] RXDATA = 8'h4c;

   localparam int TX_FULL_BIT    = 31;
   localparam int RX_EMPTY_BIT   = 31;
   localparam int RX_OVERRUN_BIT = 30;
   localparam int CSMODE_BIT     = 1;
   localparam int LOOP_BIT       = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      LOW  = 3'd2,
      HIGH = 3'd3,
      DONE = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_mmio_ctrl_if.sv
// Request/response bus between the system interconnect and the SPI controller.
// The controller is always ready; each request gets a response one cycle later.
interface spi_mmio_ctrl_if;
   logic        rq_en;
   logic [7:0]  rq_addr;
   logic        rq_iswrite;
   logic [31:0] rq_data;
   logic        rs_en;
   logic [31:0] rs_data;

   modport master (output rq_en, rq_addr, rq_iswrite, rq_data, input rs_en, rs_data);
   modport slave  (input rq_en, rq_addr, rq_iswrite, rq_data, output rs_en, rs_data);
endinterface

// File: rtl/spi_mmio_ctrl_byte_fifo.sv
// Byte FIFO with first-word fall-through read. Push while full and pop while
// empty are ignored; flags reflect the count before the current cycle.
module byte_fifo #(
   parameter int LG_FIFO = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       full,
   output logic       empty
);

   localparam int DEPTH = 1 << LG_FIFO;

   logic [LG_FIFO:0] wr_ptr;
   logic [LG_FIFO:0] rd_ptr;
   logic [7:0]       mem [DEPTH];

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[LG_FIFO] != rd_ptr[LG_FIFO]) &&
                     (wr_ptr[LG_FIFO-1:0] == rd_ptr[LG_FIFO-1:0]);
   assign pop_data = mem[rd_ptr[LG_FIFO-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[LG_FIFO-1:0]] <= push_data;
   end

endmodule

// File: rtl/spi_mmio_ctrl.sv
// Memory-mapped mode-0 SPI master with TX/RX byte FIFOs and programmable SCK divider.
// Build option SPI_LOOPBACK_EN adds the internal loopback register at offset 0x40.
//
// state | meaning
// IDLE  | waiting for a byte in the TX FIFO
// LOAD  | pop TX head into the shift register, present MSB
// LOW   | spi_clk low half-period
// HIGH  | spi_clk high half-period; input bit sampled on entry
// DONE  | push received byte into RX (or flag overrun)
module spi_mmio_ctrl
   import spi_pkg::*;
#(
   parameter int                LG_FIFO   = 3,
   parameter int                DIV_W     = 12,
   parameter logic [DIV_W-1:0]  DIV_RESET = '0
) (
   input  logic            clk,
   input  logic            resetn,
   spi_mmio_ctrl_if.slave  bus,
   output logic            spi_clk,
   output logic            spi_mosi,
   input  logic            spi_miso,
   output logic            spi_csn,
   output logic            busy
);

   spi_state_e state, state_nxt;

   logic [DIV_W-1:0] sckdiv, cnt;
   logic [7:0]       shreg, rxshreg, tx_head, rx_head;
   logic [3:0]       bitcnt;
   logic             csmode, overrun, miso_bit;
   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic             tx_pop, rx_push, reload, do_load, do_sample, do_shift, bit_done;
   logic             rd, wr, tx_push, rx_pop;
   logic [31:0]      rd_mux;
   logic             expire;
   logic             unused_rq;

   assign rd        = bus.rq_en && !bus.rq_iswrite;
   assign wr        = bus.rq_en &&  bus.rq_iswrite;
   assign tx_push   = wr && (bus.rq_addr == TXDATA);
   assign rx_pop    = rd && (bus.rq_addr == RXDATA);
   assign expire    = (cnt == '0);
   assign busy      = (state != IDLE) || !tx_empty;
   assign unused_rq = ^bus.rq_data;

`ifdef SPI_LOOPBACK_EN
   logic loop_en;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         loop_en <= 1'b0;
      else if (wr && (bus.rq_addr == LOOP))
         loop_en <= bus.rq_data[LOOP_BIT];
   end

   assign miso_bit = loop_en ? spi_mosi : spi_miso;
   assign spi_csn  = loop_en | ~csmode;
`else
   assign miso_bit = spi_miso;
   assign spi_csn  = ~csmode;
`endif

   byte_fifo #(.LG_FIFO(LG_FIFO)) u_tx_fifo (
      .clk, .resetn, .push(tx_push), .push_data(bus.rq_data[7:0]), .pop(tx_pop),
      .pop_data(tx_head), .full(tx_full), .empty(tx_empty)
   );

   byte_fifo #(.LG_FIFO(LG_FIFO)) u_rx_fifo (
      .clk, .resetn, .push(rx_push), .push_data(rxshreg), .pop(rx_pop),
      .pop_data(rx_head), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      reload    = 1'b0;
      do_load   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      bit_done  = 1'b0;
      case (state)
         IDLE: if (!tx_empty) state_nxt = LOAD;
         LOAD: begin
            tx_pop    = 1'b1;
            do_load   = 1'b1;
            reload    = 1'b1;
            state_nxt = LOW;
         end
         LOW: if (expire) begin
            reload    = 1'b1;
            do_sample = 1'b1;
            state_nxt = HIGH;
         end
         HIGH: if (expire) begin
            reload   = 1'b1;
            bit_done = 1'b1;
            if (bitcnt > 4'd1) begin
               do_shift  = 1'b1;
               state_nxt = LOW;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            rx_push   = 1'b1;
            state_nxt = tx_empty ? IDLE : LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Half-period timer: reloaded on every phase entry so divider writes land there.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         shreg    <= '0;
         rxshreg  <= '0;
         bitcnt   <= '0;
         spi_mosi <= 1'b0;
         spi_clk  <= 1'b0;
      end else begin
         if (reload)
            cnt <= sckdiv;
         else if (!expire)
            cnt <= cnt - DIV_W'(1);
         if (do_load) begin
            shreg    <= tx_head;
            spi_mosi <= tx_head[7];
            bitcnt   <= 4'd8;
         end
         if (do_sample)
            rxshreg <= {rxshreg[6:0], miso_bit};
         if (bit_done)
            bitcnt <= bitcnt - 4'd1;
         if (do_shift) begin
            shreg    <= {shreg[6:0], 1'b0};
            spi_mosi <= shreg[6];
         end
         spi_clk <= (state_nxt == HIGH);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.rq_addr)
         SCKDIV: rd_mux[DIV_W-1:0]        = sckdiv;
         CSMODE: rd_mux[CSMODE_BIT]       = csmode;
         TXDATA: rd_mux[TX_FULL_BIT]      = tx_full;
         RXDATA: begin
            if (rx_empty) begin
               rd_mux[RX_EMPTY_BIT] = 1'b1;
            end else begin
               rd_mux[RX_OVERRUN_BIT] = overrun;
               rd_mux[7:0]            = rx_head;
            end
         end
`ifdef SPI_LOOPBACK_EN
         LOOP:   rd_mux[LOOP_BIT]         = loop_en;
`endif
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sckdiv      <= DIV_RESET;
         csmode      <= 1'b0;
         overrun     <= 1'b0;
         bus.rs_en   <= 1'b0;
         bus.rs_data <= '0;
      end else begin
         if (wr && (bus.rq_addr == SCKDIV))
            sckdiv <= bus.rq_data[DIV_W-1:0];
         if (wr && (bus.rq_addr == CSMODE))
            csmode <= bus.rq_data[CSMODE_BIT];
         // A drop in the same cycle as a pop still reports overrun on the next read.
         if (rx_pop && !rx_empty)
            overrun <= 1'b0;
         if (rx_push && rx_full)
            overrun <= 1'b1;
         bus.rs_en   <= bus.rq_en;
         bus.rs_data <= rd ? rd_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_spi_mmio_ctrl.sv
// Scoreboard bench for spi_mmio_ctrl: randomized traffic against a queue-level
// model of the FIFOs, plus a pin monitor that decodes the serial bytes.
module tb_spi_mmio_ctrl;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic spi_clk, spi_mosi, spi_miso, spi_csn, busy;
   logic flip = 1'b0;

   initial forever #5 clk = ~clk;

   spi_mmio_ctrl_if bus();

   assign spi_miso = spi_mosi ^ flip;

   spi_mmio_ctrl dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_csn  (spi_csn),
      .busy     (busy)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  wire_q[$];
   logic [7:0]  rx_m[$];
   logic        ovr_m = 1'b0;
   int          tx_cnt_m = 0;
   int          cur_div = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Response monitor
   initial forever begin
      @(negedge clk);
      if (resetn && bus.rs_en) begin
         if (exp_q.size() == 0)
            chk("rs_unexpected", 32'd1, 32'd0);
         else
            chk("rs_data", bus.rs_data, exp_q.pop_front());
      end
   end

   // Serial pin monitor: phase lengths and bytes as they appear on the wire
   int          prun = 0;
   int          pbits = 0;
   logic        pprev = 1'b0;
   logic [7:0]  pbyte = 8'h0;
   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         prun = 0; pbits = 0; pprev = 1'b0;
      end else if (spi_clk != pprev) begin
         if (spi_clk) begin
            if (pbits != 0) chk("low_phase", 32'(prun), 32'(cur_div + 1));
            pbyte = {pbyte[6:0], spi_mosi};
            pbits++;
         end else begin
            chk("high_phase", 32'(prun), 32'(cur_div + 1));
            if (pbits == 8) begin
               if (wire_q.size() == 0) chk("extra_byte", {24'h0, pbyte}, 32'hFFFF_FFFF);
               else                    chk("mosi_byte", {24'h0, pbyte}, {24'h0, wire_q.pop_front()});
               pbits = 0;
            end
         end
         prun  = 1;
         pprev = spi_clk;
      end else begin
         prun++;
      end
   end

   task automatic bus_op(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [31:0] e);
      bus.rq_en = 1'b1; bus.rq_addr = a; bus.rq_iswrite = w; bus.rq_data = d;
      exp_q.push_back(e);
      @(negedge clk);
      bus.rq_en = 1'b0; bus.rq_iswrite = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus_op(a, 1'b1, d, 32'h0);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e);
      bus_op(a, 1'b0, $urandom, e);
   endtask

   function automatic logic [31:0] model_rx_read();
      logic [31:0] r;
      if (rx_m.size() == 0) return 32'h8000_0000;
      r = {1'b0, ovr_m, 22'h0, rx_m.pop_front()};
      ovr_m = 1'b0;
      return r;
   endfunction

   task automatic rd_rx();
      rd(8'h4c, model_rx_read());
   endtask

   task automatic tx_write(input logic [7:0] b);
      if (tx_cnt_m < 8) begin
         tx_cnt_m++;
         wire_q.push_back(b);
         if (rx_m.size() < 8) rx_m.push_back(b ^ {8{flip}});
         else                 ovr_m = 1'b1;
      end
      wr(8'h48, {$urandom, b} >> 0);
   endtask

   task automatic set_div(input int d);
      wr(8'h00, 32'(d));
      cur_div = d;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
      chk("bytes_shifted_left", 32'(wire_q.size()), 32'd0);
      tx_cnt_m = 0;
   endtask

   // First byte starts the engine; once it is shifting, the rest queue behind it.
   task automatic send(input int n, input logic [7:0] first);
      tx_write(first);
      repeat (3) @(negedge clk);
      tx_cnt_m = 0;
      for (int i = 1; i < n; i++) tx_write(8'($urandom));
      rd(8'h48, (tx_cnt_m == 8) ? 32'h8000_0000 : 32'h0);
      wait_idle();
   endtask

   task automatic drain_rx();
      while (rx_m.size() > 0) rd_rx();
      rd_rx();
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] d;
      int          falls, n, nr;
      logic        prev;

      bus.rq_en = 1'b0; bus.rq_addr = 8'h0; bus.rq_iswrite = 1'b0; bus.rq_data = 32'h0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_csn",  {31'h0, spi_csn},  32'd1);
      chk("rst_sclk", {31'h0, spi_clk},  32'd0);
      chk("rst_mosi", {31'h0, spi_mosi}, 32'd0);
      chk("rst_rs_en", {31'h0, bus.rs_en}, 32'd0);
      chk("rst_busy", {31'h0, busy},     32'd0);
      rd_rx();
      rd(8'h00, 32'h0);

      // Register access and unmapped offsets
      wr(8'h00, 32'hFFFF_FABC);
      rd(8'h00, 32'h0000_0ABC);
      wr(8'h04, 32'hFFFF_FFFF);
      rd(8'h04, 32'h0);
      rd(8'h40, 32'h0);
      rd(8'h00, 32'h0000_0ABC);

      // Chip select
      wr(8'h18, 32'h2);
      chk("csn_low", {31'h0, spi_csn}, 32'd0);
      rd(8'h18, 32'h2);
      wr(8'h18, 32'h0);
      chk("csn_high", {31'h0, spi_csn}, 32'd1);

      // Single byte, fastest divider
      set_div(0);
      send(1, 8'hA5);
      rd_rx();

      // Divider of 3
      set_div(3);
      send(1, 8'h3C);
      rd_rx();

      // RX overrun with inverted return data
      flip = 1'b1;
      set_div(0);
      send(9, 8'h5A);
      repeat (9) rd_rx();
      flip = 1'b0;

      // TX full: one shifting, 8 queued, one dropped
      send(10, 8'hC3);
      drain_rx();

      // Bus pop of empty RX in the same cycle the engine pushes
      b = 8'($urandom);
      wire_q.push_back(b);
      wr(8'h48, {24'h0, b});
      falls = 0; n = 0; prev = spi_clk;
      while (falls < 8 && n < 300) begin
         if (prev && !spi_clk) falls++;
         prev = spi_clk;
         if (falls < 8) begin
            @(negedge clk);
            n++;
         end
      end
      chk("sim_reached_done", 32'(falls), 32'd8);
      rd(8'h4c, 32'h8000_0000);
      rx_m.push_back(b);
      rd_rx();
      wait_idle();

      // Randomized traffic
      for (int it = 0; it < 8; it++) begin
         flip = 1'($urandom_range(0, 1));
         set_div($urandom_range(0, 3));
         d = $urandom;
         wr(8'h18, d);
         chk("csn_rand", {31'h0, spi_csn}, {31'h0, ~d[1]});
         rd(8'h18, {30'h0, d[1], 1'b0});
         send($urandom_range(1, 10), 8'($urandom));
         nr = $urandom_range(0, rx_m.size() + 1);
         repeat (nr) rd_rx();
      end
      drain_rx();

      // Reset in the middle of a byte
      set_div(3);
      wr(8'h18, 32'h2);
      wr(8'h48, 32'h0000_00F0);
      repeat (30) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid_rst_sclk", {31'h0, spi_clk}, 32'd0);
      chk("mid_rst_csn",  {31'h0, spi_csn}, 32'd1);
      chk("mid_rst_busy", {31'h0, busy},    32'd0);
      chk("mid_rst_mosi", {31'h0, spi_mosi}, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      cur_div = 0; tx_cnt_m = 0; ovr_m = 1'b0;
      rx_m.delete(); wire_q.delete();
      @(negedge clk);
      rd(8'h00, 32'h0);
      rd_rx();
      chk("post_rst_busy", {31'h0, busy}, 32'd0);

      repeat (4) @(negedge clk);
      chk("rs_outstanding", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
